// File: rtl/dmem_defs.sv
// Shared definitions for the data memory block.
//   - FSM state encoding (2-bit): IDLE, BUSY, ACK
//   - Storage geometry: depth, address width, data width
//   - Latched operation kind (read or write)
package dmem_defs;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_ACK  = 2'd2
  } dmem_state_e;

  typedef enum logic {
    DMEM_OP_READ  = 1'b0,
    DMEM_OP_WRITE = 1'b1
  } dmem_op_e;

  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_AW    = 8;
  localparam int DMEM_DW    = 8;

endpackage

// File: rtl/dmem_access_timer.sv
// 4-bit down-counter that measures the BUSY phase of a memory access.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset, clears the count
//   load       - load load_value (takes priority over dec)
//   dec        - decrement by one; holds at zero
//   load_value - value loaded when an access is accepted
//   zero       - count is zero (access completes on this cycle's edge)
module dmem_access_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_value,
  output logic       zero
);

  logic [3:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/data_memory.sv
// Byte-addressed 256 x 8 data memory, responder side of the CPU's
// READ/WRITE/BUSYWAIT handshake. Every access takes ACCESS_CYCLES BUSY
// cycles followed by one ACK cycle; BUSYWAIT stalls the CPU meanwhile.
// Parameters:
//   ACCESS_CYCLES - BUSY cycles per access, legal range 1..15
// Ports:
//   CLK       - system clock, rising edge
//   RESET     - asynchronous active-high reset (clears state and memory)
//   READ      - load request
//   WRITE     - store request (READ and WRITE together = no request)
//   ADDRESS   - byte address
//   WRITEDATA - store data
//   READDATA  - registered load data
//   BUSYWAIT  - stall request to the CPU
module data_memory
  import dmem_defs::*;
#(
  parameter int unsigned ACCESS_CYCLES = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [DMEM_AW-1:0] ADDRESS,
  input  logic [DMEM_DW-1:0] WRITEDATA,
  output logic [DMEM_DW-1:0] READDATA,
  output logic               BUSYWAIT
);

  // The counter is loaded with one less than the cycle count because the
  // completing edge itself is the last BUSY cycle.
  localparam logic [3:0] TIMER_LOAD = 4'(ACCESS_CYCLES - 1);

  dmem_state_e        state;
  dmem_state_e        next_state;
  dmem_op_e           op_q;
  logic [DMEM_AW-1:0] addr_q;
  logic [DMEM_DW-1:0] data_q;
  logic [DMEM_DW-1:0] mem [DMEM_DEPTH];

  logic req_valid;
  logic accept;
  logic timer_zero;
  logic complete;

  assign req_valid = READ ^ WRITE;
  assign accept    = (state == DMEM_IDLE) && req_valid;
  assign complete  = (state == DMEM_BUSY) && timer_zero;

  dmem_access_timer u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .load       (accept),
    .dec        (state == DMEM_BUSY),
    .load_value (TIMER_LOAD),
    .zero       (timer_zero)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= DMEM_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      DMEM_IDLE: if (req_valid)  next_state = DMEM_BUSY;
      DMEM_BUSY: if (timer_zero) next_state = DMEM_ACK;
      DMEM_ACK:                  next_state = DMEM_IDLE;
      default:                   next_state = DMEM_IDLE;
    endcase
  end

  // Request capture: inputs may change during BUSY without effect.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_q   <= DMEM_OP_READ;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= WRITE ? DMEM_OP_WRITE : DMEM_OP_READ;
      addr_q <= ADDRESS;
      data_q <= WRITEDATA;
    end
  end

  // NOTE: the whole array is cleared on reset because reads after reset
  // must return 8'h00; this forces flop storage rather than a RAM macro.
  // A store aborted by reset never reaches this write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (complete && op_q == DMEM_OP_WRITE) begin
      mem[addr_q] <= data_q;
    end
  end

  // Load data holds until the next completed read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      READDATA <= '0;
    end else if (complete && op_q == DMEM_OP_READ) begin
      READDATA <= mem[addr_q];
    end
  end

  // Stall rises in the same cycle a request appears and is dropped in ACK.
  // Reset forces it low even if a request is still presented.
  assign BUSYWAIT = !RESET && (accept || state == DMEM_BUSY);

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory. The stimulus tasks maintain a
// transaction-level model (byte array plus expected BUSYWAIT/READDATA per
// cycle); a negedge process compares the DUT against it every cycle, and
// literal checks after each scenario pin the model.
module tb_data_memory;

  localparam int AC = 5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  int checks = 0;
  int errors = 0;
  int busy_seen = 0;

  logic       exp_busy;
  logic [7:0] exp_rd;
  logic [7:0] model_mem [256];

  data_memory #(.ACCESS_CYCLES(AC)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    check("busywait", {7'b0, BUSYWAIT}, {7'b0, exp_busy});
    check("readdata", READDATA, exp_rd);
    if (BUSYWAIT === 1'b1) busy_seen++;
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
  endtask

  // One complete access: request cycle, AC BUSY cycles, ACK cycle with the
  // request still held, then the request is dropped in the following cycle.
  // When disturb is set, ADDRESS/WRITEDATA change mid-BUSY.
  task automatic access(input bit is_write, input logic [7:0] addr,
                        input logic [7:0] data, input bit disturb,
                        input logic [7:0] alt_addr, input logic [7:0] alt_data);
    next_cycle();
    ADDRESS   = addr;
    WRITEDATA = data;
    READ      = !is_write;
    WRITE     = is_write;
    exp_busy  = 1'b1;
    for (int c = 1; c <= AC; c++) begin
      next_cycle();
      if (disturb && c == 2) begin
        ADDRESS   = alt_addr;
        WRITEDATA = alt_data;
      end
    end
    next_cycle();
    exp_busy = 1'b0;
    if (is_write) model_mem[addr] = data;
    else          exp_rd = model_mem[addr];
    next_cycle();
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  initial begin
    RESET     = 1'b1;
    READ      = 1'b0;
    WRITE     = 1'b0;
    ADDRESS   = 8'h00;
    WRITEDATA = 8'h00;
    exp_busy  = 1'b0;
    exp_rd    = 8'h00;
    clear_model();
    repeat (2) next_cycle();
    RESET = 1'b0;
    next_cycle();

    // 1: read of a cleared location, 6-cycle stall.
    busy_seen = 0;
    access(1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00);
    check("t1_busy_cycles", 8'(busy_seen), 8'd6);
    check("t1_readdata", READDATA, 8'h00);

    // 2: store then back-to-back load of the same address.
    access(1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, 8'h00);
    check("t2_rd_after_write", READDATA, 8'h00);
    access(1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00);
    check("t2_readdata", READDATA, 8'hA5);

    // 3: inputs change mid-BUSY; the latched values win.
    access(1'b1, 8'hFF, 8'h11, 1'b1, 8'h00, 8'h22);
    access(1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00);
    check("t3_mem_ff", READDATA, 8'h11);
    access(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    check("t3_mem_00", READDATA, 8'h00);

    // 4: READ and WRITE together is no request.
    busy_seen = 0;
    next_cycle();
    READ      = 1'b1;
    WRITE     = 1'b1;
    ADDRESS   = 8'h3C;
    WRITEDATA = 8'h00;
    repeat (10) next_cycle();
    READ  = 1'b0;
    WRITE = 1'b0;
    check("t4_busy_cycles", 8'(busy_seen), 8'd0);
    access(1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00);
    check("t4_mem_3c", READDATA, 8'hA5);

    // 5: asynchronous reset three cycles into a store.
    next_cycle();
    ADDRESS   = 8'h20;
    WRITEDATA = 8'h5A;
    WRITE     = 1'b1;
    exp_busy  = 1'b1;
    repeat (3) next_cycle();
    #2;
    RESET    = 1'b1;
    WRITE    = 1'b0;
    exp_busy = 1'b0;
    exp_rd   = 8'h00;
    clear_model();
    #1;
    check("t5_busy_now", {7'b0, BUSYWAIT}, 8'h00);
    check("t5_rd_now", READDATA, 8'h00);
    repeat (2) next_cycle();
    RESET = 1'b0;
    access(1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00);
    check("t5_mem_20", READDATA, 8'h00);

    // 6: request held through ACK yields exactly one access.
    access(1'b1, 8'h3C, 8'hC3, 1'b0, 8'h00, 8'h00);
    busy_seen = 0;
    access(1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00);
    next_cycle();
    check("t6_busy_cycles", 8'(busy_seen), 8'd6);
    check("t6_readdata", READDATA, 8'hC3);

    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
